// File: rtl/flappy_pkg.sv
// flappy_pkg: shared types and grid constants for the Flappy Bird pipeline.
//   bird_state_t : vertical-motion FSM states (IDLE, RISE, FALL, CRASH)
//   GRID_ROWS    : default LED grid height
//   GRID_COLS    : default LED grid width
package flappy_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RISE  = 2'd1,
      FALL  = 2'd2,
      CRASH = 2'd3
   } bird_state_t;

   localparam int GRID_ROWS = 16;
   localparam int GRID_COLS = 16;

endpackage

// File: rtl/bird_motion_tick_gen.sv
// tick_gen: movement-tick divider for the bird motion stage.
//   clk    in  system clock
//   reset  in  synchronous, active-high
//   enable in  counter advances only while high
//   tick   out high on the last count of each period while enabled
module tick_gen #(
   parameter int TICK_DIV = 25
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);

   logic [CW-1:0] count;

   assign tick = enable && (count == CW'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (enable) begin
         if (tick) count <= '0;
         else      count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/bird_motion.sv
// bird_motion: vertical-motion stage of the Flappy Bird game.
//   clk      in  system clock
//   reset    in  synchronous, active-high
//   flap     in  one-cycle flap pulse from the input stage
//   enable   in  game running; low freezes all motion and drops flaps
//   row_pos  out current bird row (0 = top, ROWS-1 = floor)
//   bird_row out one-hot decode of row_pos for the display
//   rising   out high while the bird is in RISE
//   crash    out sticky crash flag, cleared only by reset
// Build option: BIRD_CEILING_CRASH_EN makes a RISE tick at row 0 a crash;
// otherwise the bird clamps at the top row.
module bird_motion
   import flappy_pkg::*;
#(
   parameter int ROWS        = GRID_ROWS,
   parameter int START_ROW   = 8,
   parameter int FLAP_HEIGHT = 3,
   parameter int TICK_DIV    = 25
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flap,
   input  logic                    enable,
   output logic [$clog2(ROWS)-1:0] row_pos,
   output logic [ROWS-1:0]         bird_row,
   output logic                    rising,
   output logic                    crash
);

   localparam int RW = $clog2(ROWS);
   localparam int HW = $clog2(FLAP_HEIGHT + 1);

   bird_state_t   state;
   logic [HW-1:0] rise_cnt;
   logic          tick;

   function automatic logic [ROWS-1:0] onehot(input logic [RW-1:0] r);
      return {{(ROWS-1){1'b0}}, 1'b1} << r;
   endfunction

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .tick   (tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         rise_cnt <= '0;
         row_pos  <= RW'(START_ROW);
         bird_row <= onehot(RW'(START_ROW));
         rising   <= 1'b0;
         crash    <= 1'b0;
      end else if (enable) begin
         case (state)
            IDLE: begin
               if (flap) begin
                  state    <= RISE;
                  rise_cnt <= HW'(FLAP_HEIGHT);
                  rising   <= 1'b1;
               end
            end

            RISE, FALL: begin
               // A flap coinciding with a tick swallows that tick's movement.
               if (flap) begin
                  state    <= RISE;
                  rise_cnt <= HW'(FLAP_HEIGHT);
                  rising   <= 1'b1;
               end else if (tick) begin
                  if (state == RISE) begin
`ifdef BIRD_CEILING_CRASH_EN
                     if (row_pos == '0) begin
                        state  <= CRASH;
                        rising <= 1'b0;
                        crash  <= 1'b1;
                     end else begin
                        row_pos  <= row_pos - RW'(1);
                        bird_row <= onehot(row_pos - RW'(1));
                        rise_cnt <= rise_cnt - HW'(1);
                        if (rise_cnt == HW'(1)) begin
                           state  <= FALL;
                           rising <= 1'b0;
                        end
                     end
`else
                     if (row_pos != '0) begin
                        row_pos  <= row_pos - RW'(1);
                        bird_row <= onehot(row_pos - RW'(1));
                     end
                     rise_cnt <= rise_cnt - HW'(1);
                     if (rise_cnt == HW'(1)) begin
                        state  <= FALL;
                        rising <= 1'b0;
                     end
`endif
                  end else begin
                     if (row_pos == RW'(ROWS - 1)) begin
                        state <= CRASH;
                        crash <= 1'b1;
                     end else begin
                        row_pos  <= row_pos + RW'(1);
                        bird_row <= onehot(row_pos + RW'(1));
                     end
                  end
               end
            end

            CRASH: begin
               crash  <= 1'b1;
               rising <= 1'b0;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
